imem_fetch_ctrl: RTL and testbench

Fetch-side controller for the single-cycle-read instruction memory. It owns the program counter and sequences fetches into the IF/ID register, applying hazard stalls and branch/jump redirects. It also shares the memory's single address port with a program loader that writes instruction words while the core is not running. It sits between the hazard/branch logic of the pipeline and the instruction memory.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_port_mux.sv | 31 +++
 rtl/imem_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
// The alignment check is enabled by defining IMEM_FETCH_ALIGN_CHK_EN.
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/imem_port_mux.sv
// Single memory port shared between the fetch path (RUN) and the program loader.
// The loader is acknowledged combinationally whenever the fetch does not own the port.
module imem_port_mux
  import imem_pkg::*;
(
  input  logic               fetch_own_i,
  input  logic [INSTR_W-1:0] fetch_addr_i,
  input  logic               load_req_i,
  input  logic [INSTR_W-1:0] load_addr_i,
  input  logic [INSTR_W-1:0] load_data_i,
  output logic [INSTR_W-1:0] imem_addr_o,
  output logic               imem_we_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic               load_ack_o
);

  always_comb begin
    imem_addr_o  = load_addr_i;
    imem_we_o    = load_req_i;
    imem_wdata_o = load_data_i;
    load_ack_o   = load_req_i;
    if (fetch_own_i) begin
      // Loader is held off, not dropped: it keeps requesting until the core stops.
      imem_addr_o  = fetch_addr_i;
      imem_we_o    = 1'b0;
      imem_wdata_o = NOP_INSTR;
      load_ack_o   = 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the PC and the IF/ID register, sequences fetch, stall and redirect.
// Define IMEM_FETCH_ALIGN_CHK_EN to halt with err on misaligned redirect targets.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ack,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic        err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         if_valid_q, if_valid_d;
  logic         err_q, err_d;
  logic         pc_oor;
  logic         misalign;
  logic [31:0]  redirect_tgt;

  // Word index compared against DEPTH; also catches a wrapped pc+4 before it is fetched.
  assign pc_oor       = ({2'b00, pc_q[31:2]} >= 32'(DEPTH));
  assign redirect_tgt = redirect_pc & ~32'h3;

`ifdef IMEM_FETCH_ALIGN_CHK_EN
  assign misalign = |redirect_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    err_d      = err_q;
    case (state_q)
      IDLE, HALT: begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          if (misalign) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (stall) begin
          // Hold everything; a pending out-of-range halt waits for the stall to clear.
        end else if (pc_oor) begin
          state_d    = HALT;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else begin
          pc_d       = pc_q + 32'd4;
          if_pc_d    = pc_q;
          if_instr_d = imem_rdata;
          if_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      err_q      <= err_d;
    end
  end

  imem_port_mux u_port_mux (
    .fetch_own_i  (state_q == RUN),
    .fetch_addr_i (pc_q),
    .load_req_i   (load_req),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .imem_addr_o  (imem_addr),
    .imem_we_o    (imem_we),
    .imem_wdata_o (imem_wdata),
    .load_ack_o   (load_ack)
  );

  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_valid = if_valid_q;
  assign halted   = (state_q == HALT);

`ifdef IMEM_FETCH_ALIGN_CHK_EN
  assign err = err_q;
`else
  // Without the alignment check there is no fault source.
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 32-word memory.
// Covers both builds of IMEM_FETCH_ALIGN_CHK_EN.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        load_req;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ack;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic        err;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  int          n_chk;
  int          n_fail;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load_req       (load_req),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_ack       (load_ack),
    .imem_addr      (imem_addr),
    .imem_we        (imem_we),
    .imem_wdata     (imem_wdata),
    .imem_rdata     (imem_rdata),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .halted         (halted),
    .err            (err)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we && (imem_addr[31:7] == 25'd0)) mem[imem_addr[6:2]] <= imem_wdata;
  end

  assign imem_rdata = (imem_addr[31:7] == 25'd0) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic with_stall);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    stall          = with_stall;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {8'hA5, 8'(i), 16'hC0DE};
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst_n = 1'b1; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; load_req = 1'b0; load_addr = 32'h0; load_data = 32'h0;

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_halted", halted, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_load_ack", load_ack, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // load 30 words, plus one write beyond DEPTH that memory must ignore
    for (int i = 0; i < 30; i++) begin
      load_req   = 1'b1;
      load_addr  = 32'(i * 4);
      load_data  = word_of(i);
      ref_mem[i] = word_of(i);
      #1;
      chk("load_ack_idle", load_ack, 1'b1);
      chk("load_we_idle", imem_we, 1'b1);
      chk("load_addr_idle", imem_addr, 32'(i * 4));
      tick();
    end
    load_addr = 32'h100;
    load_data = 32'hBAD0_BAD0;
    #1;
    chk("load_ack_oor", load_ack, 1'b1);
    tick();
    load_req = 1'b0;

    // sequential run to the end of memory with loader held off
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_mem[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_if_valid", if_valid, 1'b0);
    chk("start_halted", halted, 1'b0);
    load_req  = 1'b1;
    load_addr = 32'h100;
    load_data = 32'h5555_AAAA;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("run_load_ack", load_ack, 1'b0);
      chk("run_imem_we", imem_we, 1'b0);
      chk("run_imem_addr", imem_addr, 32'(i * 4));
      tick();
      chk("seq_if_valid", if_valid, 1'b1);
      chk("seq_if_pc", if_pc, 32'(i * 4));
      chk("seq_if_instr", if_instr, exp_q.pop_front());
    end
    chk("last_load_ack", load_ack, 1'b0);
    tick();
    chk("end_halted", halted, 1'b1);
    chk("end_if_valid", if_valid, 1'b0);
    chk("end_err", err, 1'b0);
    chk("halt_load_ack", load_ack, 1'b1);
    chk("halt_imem_we", imem_we, 1'b1);
    load_req = 1'b0;

    // redirect from pc=0x24 to 0x38
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_halted", halted, 1'b0);
    repeat (9) tick();
    chk("pre_redir_if_pc", if_pc, 32'h20);
    redirect(32'h38, 1'b0);
    chk("redir_bubble_valid", if_valid, 1'b0);
    chk("redir_bubble_instr", if_instr, 32'h0);
    tick();
    chk("redir_if_pc", if_pc, 32'h38);
    chk("redir_if_instr", if_instr, ref_mem[14]);
    chk("redir_if_valid", if_valid, 1'b1);

    // stall three cycles with pc=0x10
    redirect(32'h0C, 1'b0);
    tick();
    chk("prestall_if_pc", if_pc, 32'h0C);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_if_pc", if_pc, 32'h0C);
      chk("stall_if_instr", if_instr, ref_mem[3]);
      chk("stall_if_valid", if_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_if_pc", if_pc, 32'h10);
    chk("unstall_if_instr", if_instr, ref_mem[4]);

    // stall and redirect together: redirect wins
    redirect(32'h48, 1'b1);
    chk("sr_bubble_valid", if_valid, 1'b0);
    chk("sr_bubble_instr", if_instr, 32'h0);
    tick();
    chk("sr_if_pc", if_pc, 32'h48);
    chk("sr_if_instr", if_instr, ref_mem[18]);
    chk("sr_if_valid", if_valid, 1'b1);

    // misaligned redirect target
    redirect(32'h3A, 1'b0);
`ifdef IMEM_FETCH_ALIGN_CHK_EN
    chk("mis_halted", halted, 1'b1);
    chk("mis_err", err, 1'b1);
    chk("mis_if_valid", if_valid, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mis_restart_err", err, 1'b0);
    chk("mis_restart_halted", halted, 1'b0);
`else
    chk("mis_bubble_valid", if_valid, 1'b0);
    tick();
    chk("mis_if_pc", if_pc, 32'h38);
    chk("mis_if_instr", if_instr, ref_mem[14]);
    chk("mis_err", err, 1'b0);
`endif

    // asynchronous reset mid-run
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halted", halted, 1'b0);
    chk("arst_if_valid", if_valid, 1'b0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_err", err, 1'b0);
    load_req = 1'b1;
    #1;
    chk("arst_idle_load_ack", load_ack, 1'b1);
    load_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // start in the same cycle as a loader write
    load_req   = 1'b1;
    load_addr  = 32'h0;
    load_data  = 32'h1234_5678;
    ref_mem[0] = 32'h1234_5678;
    start      = 1'b1;
    #1;
    chk("ls_load_ack", load_ack, 1'b1);
    tick();
    load_req = 1'b0;
    start    = 1'b0;
    chk("ls_halted", halted, 1'b0);
    chk("ls_if_valid", if_valid, 1'b0);
    chk("ls_imem_we", imem_we, 1'b0);
    tick();
    chk("ls_if_pc", if_pc, 32'h0);
    chk("ls_if_instr", if_instr, ref_mem[0]);
    chk("ls_if_valid_after", if_valid, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
